cseladd_pipe2: RTL and testbench

Two-stage pipelined 32-bit carry-select adder with valid/ready handshakes on both sides. Stage 1 registers the low 16-bit sum and carry together with both speculative upper-half sums (carry-in 0 and carry-in 1). Stage 2 selects the upper half using the registered low carry and holds the result until it is consumed. It sits directly downstream of the operand source and replaces the purely combinational 32-bit carry-select adder wherever the sum feeds a registered, flow-controlled datapath.

---
 rtl/cseladd_pipe2.sv | 162 ++++++++++++++++
 tb/tb_cseladd_pipe2.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cseladd_pipe2.sv
// -----------------------------------------------------------------------------
// cseladd_pipe2 -- two-stage pipelined 32-bit carry-select adder.
//
// Stage 1 computes the low 16-bit half-sum and its carry, plus both possible
// upper half-sums (one assuming carry-in 0, one assuming carry-in 1), and
// registers all of them. Stage 2 uses the registered low carry to pick the
// correct upper half and holds the result until the consumer takes it.
// Each stage has a valid bit, so up to two transactions can be in flight.
//
// Build option:
//   CSELADD_PIPE2_SAT_EN  - when defined, a carry out of bit 31 saturates the
//                           sum to 32'hFFFF_FFFF. cout still reports the raw
//                           carry. Handshake and latency are the same as in
//                           the wrapping build.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b are present
//   in_ready   out  stage 1 can accept this cycle (depends only on state and
//                   out_ready, never on in_valid)
//   a, b       in   32-bit unsigned operands
//   out_valid  out  sum/cout hold a valid result
//   out_ready  in   consumer takes the result this cycle
//   sum        out  registered 32-bit sum
//   cout       out  registered carry out of bit 31
// -----------------------------------------------------------------------------
module cseladd_pipe2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Stage 1: low half-sum, low carry, both speculative upper half-sums.
  logic        v1_q,   v1_d;
  logic [15:0] lo_q,   lo_d;
  logic        lo_c_q, lo_c_d;
  logic [16:0] hi0_q,  hi0_d;
  logic [16:0] hi1_q,  hi1_d;

  // Stage 2: the selected result.
  logic        v2_q,   v2_d;
  logic [31:0] sum_q,  sum_d;
  logic        cout_q, cout_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s2_free;   // stage 2 is empty or is being emptied this cycle
  logic accept;    // input transfer
  logic advance;   // stage 1 moves into stage 2

  always_comb begin
    s2_free  = !v2_q || out_ready;
    // Stage 1 can take new data if it is empty, or if its current content
    // moves on this same cycle. This is what gives full throughput.
    in_ready = !v1_q || s2_free;
    accept   = in_valid && in_ready;
    advance  = v1_q && s2_free;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: half-sums
  // ---------------------------------------------------------------------------
  logic [16:0] lo_full;
  logic [16:0] hi_base;

  always_comb begin
    lo_full = {1'b0, a[15:0]}  + {1'b0, b[15:0]};
    hi_base = {1'b0, a[31:16]} + {1'b0, b[31:16]};

    v1_d   = v1_q;
    lo_d   = lo_q;
    lo_c_d = lo_c_q;
    hi0_d  = hi0_q;
    hi1_d  = hi1_q;

    if (accept) begin
      v1_d   = 1'b1;
      lo_d   = lo_full[15:0];
      lo_c_d = lo_full[16];
      hi0_d  = hi_base;
      // Largest case is 0xFFFF + 0xFFFF + 1 = 0x1FFFF, so 17 bits are enough.
      hi1_d  = hi_base + 17'd1;
    end else if (s2_free) begin
      // Stage 1 is drained (or was already empty). Its data registers keep
      // their values because only v1 decides whether they mean anything.
      v1_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: carry select
  // ---------------------------------------------------------------------------
  logic [15:0] hi_sel;
  logic        c_sel;

  always_comb begin
    hi_sel = lo_c_q ? hi1_q[15:0] : hi0_q[15:0];
    c_sel  = lo_c_q ? hi1_q[16]   : hi0_q[16];

    v2_d   = v2_q;
    sum_d  = sum_q;
    cout_d = cout_q;

    if (advance) begin
      v2_d   = 1'b1;
      cout_d = c_sel;
`ifdef CSELADD_PIPE2_SAT_EN
      sum_d  = c_sel ? 32'hFFFF_FFFF : {hi_sel, lo_q};
`else
      sum_d  = {hi_sel, lo_q};
`endif
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
    // If neither branch is taken, the result is held. This covers
    // out_valid && !out_ready, which requires a stable sum/cout.
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      lo_q   <= '0;
      lo_c_q <= 1'b0;
      hi0_q  <= '0;
      hi1_q  <= '0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      lo_q   <= lo_d;
      lo_c_q <= lo_c_d;
      hi0_q  <= hi0_d;
      hi1_q  <= hi1_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  // Every output comes straight from a flop except in_ready. in_ready is
  // combinational from v1/v2/out_ready and has no path from a or b.
  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cseladd_pipe2.sv
module tb_cseladd_pipe2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;

  int checks   = 0;
  int failures = 0;

  cseladd_pipe2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected sum for a result whose true carry out is c. Only used on the
  // random path, where the bench computes the 33-bit sum itself.
  function automatic logic [31:0] exp_sum(input logic [32:0] full);
`ifdef CSELADD_PIPE2_SAT_EN
    return full[32] ? 32'hFFFF_FFFF : full[31:0];
`else
    return full[31:0];
`endif
  endfunction

  // Inputs are driven and outputs sampled on the falling edge, so the
  // handshake seen here is the one that takes effect at the next rising edge.
  task automatic nedge();
    @(negedge clk);
  endtask

  logic [32:0] q_exp[$];
  logic [32:0] e;
  logic [31:0] ra, rb;
  int          got;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

    // ---------------- reset state ----------------
    nedge(); nedge();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       sum,                32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;

    // ---------------- carry crossing halves ----------------
    nedge();
    a = 32'h0000_FFFF; b = 32'h0000_0001; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("cross_in_ready", {31'd0, in_ready}, 32'd1);
    nedge(); in_valid = 1'b0;
    check("cross_lat_not_yet", {31'd0, out_valid}, 32'd0);
    nedge();
    check("cross_valid", {31'd0, out_valid}, 32'd1);
    check("cross_sum",   sum,                32'h0001_0000);
    check("cross_cout",  {31'd0, cout},      32'd0);
    nedge();
    check("cross_drained", {31'd0, out_valid}, 32'd0);

    // ---------------- full overflow ----------------
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
    nedge(); in_valid = 1'b0;
    nedge();
    check("ovf_valid", {31'd0, out_valid}, 32'd1);
`ifdef CSELADD_PIPE2_SAT_EN
    check("ovf_sum",   sum, 32'hFFFF_FFFF);
`else
    check("ovf_sum",   sum, 32'h0000_0000);
`endif
    check("ovf_cout",  {31'd0, cout}, 32'd1);
    nedge();

    // ---------------- streaming: 8 back-to-back ----------------
    // Input k is driven on cycle k and is on the outputs on cycle k+2.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        a = 32'(c + 1); b = 32'h1000_0000 * 32'(c + 1); in_valid = 1'b1;
        #1 check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
        #1;
      end
      if (c >= 2) begin
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_sum",   sum, 32'h1000_0001 * 32'(c - 1));
      end
      nedge();
    end
    check("stream_end", {31'd0, out_valid}, 32'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    a = 32'h0000_0001; b = 32'h0000_0002; in_valid = 1'b1;              // p0 -> 3
    #1 check("bp_acc0", {31'd0, in_ready}, 32'd1);
    nedge();
    a = 32'h0F0F_0F0F; b = 32'h1010_1010;                               // p1 -> 1F1F1F1F
    #1 check("bp_acc1", {31'd0, in_ready}, 32'd1);
    check("bp_v_early", {31'd0, out_valid}, 32'd0);
    nedge();
    a = 32'h1234_0000; b = 32'h0000_ABCD;                               // p2 -> 1234ABCD
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
      check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
      check("bp_frozen_sum",  sum, 32'h0000_0003);
      nedge();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_out0", sum, 32'h0000_0003);
    nedge(); in_valid = 1'b0;
    check("bp_out1_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out1", sum, 32'h1F1F_1F1F);
    nedge();
    check("bp_out2_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out2", sum, 32'h1234_ABCD);
    nedge();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // ---------------- reset mid-flight ----------------
    out_ready = 1'b0;
    a = 32'h0000_0005; b = 32'h0000_0006; in_valid = 1'b1;
    nedge();
    a = 32'hFFFF_0000; b = 32'h0001_0000;
    nedge(); in_valid = 1'b0;
    check("mf_loaded_valid", {31'd0, out_valid}, 32'd1);
    check("mf_loaded_sum",   sum, 32'h0000_000B);
    #2 rst_n = 1'b0;
    #1;
    check("mf_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mf_rst_sum",   sum,                32'd0);
    check("mf_rst_cout",  {31'd0, cout},      32'd0);
    check("mf_rst_ready", {31'd0, in_ready},  32'd1);
    nedge(); nedge();
    rst_n = 1'b1;
    out_ready = 1'b1;
    a = 32'h1234_5678; b = 32'h1111_1111; in_valid = 1'b1;
    nedge(); in_valid = 1'b0;
    nedge();
    check("mf_after_valid", {31'd0, out_valid}, 32'd1);
    check("mf_after_sum",   sum, 32'h2345_6789);
    check("mf_after_cout",  {31'd0, cout}, 32'd0);
    nedge();
    check("mf_no_ghost", {31'd0, out_valid}, 32'd0);

    // ---------------- random with scoreboard ----------------
    for (int c = 0; c < 3000; c++) begin
      ra = $urandom(); rb = $urandom();
      if ((c % 7) == 0) rb = ~ra;                 // carry chain fully propagating
      a = ra; b = rb;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          check("rnd_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q_exp.pop_front();
          check("rnd_sum",  sum,           exp_sum(e));
          check("rnd_cout", {31'd0, cout}, {31'd0, e[32]});
        end
      end
      if (in_valid && in_ready) q_exp.push_back({1'b0, ra} + {1'b0, rb});
      nedge();
    end
    // Drain with a bounded wait.
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && q_exp.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        e = q_exp.pop_front();
        check("drain_sum",  sum,           exp_sum(e));
        check("drain_cout", {31'd0, cout}, {31'd0, e[32]});
        got++;
      end
      nedge();
    end
    check("drain_queue_empty", 32'(q_exp.size()), 32'd0);
    #1 check("drain_no_extra", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
